// File: rtl/uart_conf_rx.sv
// Purpose: UART receiver that assembles CONF_PAR_NUM serial words into a parameter bank and commits it atomically.
// Latency: bank and conf_valid update one clk after the mid-bit sample of the last stop bit (plus 2-flop sync).
// Backpressure: none; the serial line cannot be stalled, so the bank is simply overwritten on each commit.
module uart_conf_rx #(
    parameter int CONF_PAR_MAX = 8,
    parameter int CONF_PAR_NUM = 5,
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 uart_data,
    output logic [CONF_PAR_NUM*CONF_PAR_MAX-1:0] sh_reg,
    output logic                                 conf_valid,
    output logic                                 frame_err,
    output logic                                 busy
);

    localparam int BANK_W = CONF_PAR_NUM * CONF_PAR_MAX;
    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (CONF_PAR_MAX > 1) ? $clog2(CONF_PAR_MAX) : 1;
    localparam int IDX_W  = (CONF_PAR_NUM > 1) ? $clog2(CONF_PAR_NUM) : 1;
    localparam int IDLE_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(CONF_PAR_MAX - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CONF_PAR_NUM - 1);
    localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(TO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CONF_PAR_MAX-1:0] shift_q, shift_d;
    logic [BANK_W-1:0]   stage_q, stage_d;
    logic [BANK_W-1:0]   sh_reg_q, sh_reg_d;
    logic                conf_valid_q, conf_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;

    logic                rx;
    logic                fall;
    logic [BANK_W-1:0]   stage_wr;

    assign rx   = sync2_q;
    assign fall = rx_prev_q & ~rx;

    assign sh_reg     = sh_reg_q;
    assign conf_valid = conf_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

    always_comb begin
        state_d      = state_q;
        sync1_d      = uart_data;
        sync2_d      = sync1_q;
        rx_prev_d    = rx;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        word_idx_d   = word_idx_q;
        idle_cnt_d   = idle_cnt_q;
        shift_d      = shift_q;
        stage_d      = stage_q;
        sh_reg_d     = sh_reg_q;
        conf_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        busy_d       = busy_q;

        // First word received lands in the top slot of the bank.
        stage_wr = stage_q;
        for (int i = 0; i < CONF_PAR_NUM; i++) begin
            if (word_idx_q == IDX_W'(CONF_PAR_NUM - 1 - i)) begin
                stage_wr[i*CONF_PAR_MAX +: CONF_PAR_MAX] = shift_q;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (word_idx_q != '0) begin
                    if (idle_cnt_q == IDLE_END) begin
                        stage_d     = '0;
                        word_idx_d  = '0;
                        frame_err_d = 1'b1;
                        busy_d      = 1'b0;
                        idle_cnt_d  = '0;
                    end else if (rx) begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end else begin
                        idle_cnt_d = '0;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
                // A falling edge needs the line high first, which also re-arms after a framing error.
                if (fall) begin
                    state_d    = START;
                    idle_cnt_d = '0;
                end
            end

            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (!rx) begin
                        state_d = DATA;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[CONF_PAR_MAX-2:0], rx};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx) begin
                        if (word_idx_q == LAST_IDX) begin
                            sh_reg_d     = stage_wr;
                            conf_valid_d = 1'b1;
                            stage_d      = '0;
                            word_idx_d   = '0;
                            busy_d       = 1'b0;
                        end else begin
                            stage_d    = stage_wr;
                            word_idx_d = word_idx_q + 1'b1;
                        end
                    end else begin
                        stage_d     = '0;
                        word_idx_d  = '0;
                        frame_err_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            word_idx_q   <= '0;
            idle_cnt_q   <= '0;
            shift_q      <= '0;
            stage_q      <= '0;
            sh_reg_q     <= '0;
            conf_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            rx_prev_q    <= rx_prev_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            word_idx_q   <= word_idx_d;
            idle_cnt_q   <= idle_cnt_d;
            shift_q      <= shift_d;
            stage_q      <= stage_d;
            sh_reg_q     <= sh_reg_d;
            conf_valid_q <= conf_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

endmodule
